axi_lite_master_bridge: RTL and testbench
=========================================

Name: axi_lite_master_bridge

Overview:
- Single-outstanding AXI4-Lite master that turns a simple command/response port into AXI-Lite read and write transactions.
- Sits directly upstream of the AXI-Lite memory slave and drives its five channels.
- Used by test controllers and register-access logic that should not handle AXI handshakes themselves.

Parameters:
DW, 32, data width in bits; multiple of 8; WSTRB width is DW/8.
AW, 32, address width in bits.

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  bridge accepts command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AW  transaction address
cmd_wdata  in  DW  write data
cmd_wstrb  in  DW/8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_write  out  1  response belongs to a write
rsp_rdata  out  DW  read data (0 for writes)
rsp_resp  out  2  BRESP or RRESP copy
M_AXIL_AWADDR/AWVALID/AWREADY  out/out/in  AW/1/1  write address channel
M_AXIL_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  DW/DW/8/1/1  write data channel
M_AXIL_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
M_AXIL_ARADDR/ARVALID/ARREADY  out/out/in  AW/1/1  read address channel
M_AXIL_RDATA/RRESP/RVALID/RREADY  in/in/in/out  DW/2/1/1  read data channel

Behaviour:
- One clock (ACLK); reset ARESETN is asynchronous, active-low.
- Reset values: all VALID/READY outputs 0, cmd_ready 0 during reset, all address/data/strobe/rsp registers 0, state IDLE.
- States and transitions:
  - IDLE: cmd_ready=1 (registered, derived from state). On cmd_valid&&cmd_ready, latch addr/wdata/wstrb/write and go to WR_REQ if cmd_write, else RD_REQ.
  - WR_REQ: AWVALID and WVALID rise together in the cycle after acceptance. Each drops independently the cycle after its own handshake (VALID&&READY sampled high). Address and data are held stable while VALID is high. Once both handshakes are done (same or different cycles), assert BREADY and go to WR_RESP.
  - WR_RESP: BREADY=1. On BVALID, capture BRESP, drop BREADY, set rsp_valid, rsp_write=1, rsp_rdata=0, go to RSP.
  - RD_REQ: ARVALID=1 until ARREADY is sampled, then ARVALID=0, RREADY=1, go to RD_RESP.
  - RD_RESP: on RVALID, capture RDATA/RRESP, drop RREADY, set rsp_valid, rsp_write=0, go to RSP.
  - RSP: rsp_* held stable until rsp_valid&&rsp_ready, then go to IDLE.
- VALID signals never depend combinationally on READY, and are never withdrawn before their handshake.
- Minimum latency, command accept to rsp_valid: 3 cycles against a zero-wait slave.
- Only one transaction in flight; cmd_ready=0 outside IDLE. Back-to-back commands are spaced by a mandatory IDLE cycle.
- Non-OKAY resp (SLVERR/DECERR) is passed through unchanged; the bridge never retries.
- AWREADY arriving before WREADY, after it, or in the same cycle must all complete correctly.
- Reset asserted mid-transaction: immediate return to IDLE with outputs at reset values. The in-flight command is lost and produces no response.

Optional Feature:
- Macro: AXIL_MST_STATS_EN.
- Defined: adds outputs stat_wr_count[31:0], stat_rd_count[31:0], stat_err_count[15:0].
  - wr_count and rd_count increment on each completed B or R handshake.
  - err_count increments when the captured resp != 2'b00.
  - All counters wrap modulo 2^N and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package axil_pkg:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - state encoding typedef for IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
- Optional sub-module axil_mst_stats holds the counters under the macro. No other split.

Test Plan:
Bench pairs the bridge with the AXI-Lite memory slave. Slave contents: block[addr[7:6]], word addr[5:0], preloaded 0x00000000/0x11111111/0x22222222/0x33333333.
- Read cmd addr=0x40 -> rsp_rdata=0x11111111, rsp_resp=00, rsp_write=0; ARVALID high exactly until ARREADY sampled.
- Write addr=0x85, wdata=0xDEADBEEF, wstrb=4'b0011, then read 0x85 -> rsp_resp=00, read returns 0x2222BEEF.
- Slave model with AWREADY delayed 3 cycles and WREADY immediate (and the reverse) -> single B handshake, memory word correct, no duplicate AW/W handshakes.
- rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0 throughout; next command accepted one cycle after rsp handshake.
- ARESETN pulsed low while in WR_RESP -> all VALIDs 0 asynchronously, no rsp_valid; subsequent read of 0xC0 returns 0x33333333.
- AXIL_MST_STATS_EN defined, 3 writes + 2 reads with one forced SLVERR -> wr_count=3, rd_count=2, err_count=1.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and the master bridge state encoding.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } mst_state_t;

endpackage

// File: rtl/axil_mst_stats.sv
// Transaction and error counters for the AXI-Lite master bridge (built only with AXIL_MST_STATS_EN).
module axil_mst_stats
  import axil_pkg::*;
(
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        wr_done,
  input  logic        rd_done,
  input  logic [1:0]  resp,
  output logic [31:0] stat_wr_count,
  output logic [31:0] stat_rd_count,
  output logic [15:0] stat_err_count
);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      stat_wr_count  <= '0;
      stat_rd_count  <= '0;
      stat_err_count <= '0;
    end else begin
      if (wr_done) stat_wr_count <= stat_wr_count + 32'd1;
      if (rd_done) stat_rd_count <= stat_rd_count + 32'd1;
      if ((wr_done || rd_done) && (resp != RESP_OKAY))
        stat_err_count <= stat_err_count + 16'd1;
    end
  end

endmodule

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response port.
// Optional counters are built when AXIL_MST_STATS_EN is defined.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WR_REQ  | AW and W valid, each dropped after its own handshake
// WR_RESP | BREADY high, waiting for BVALID
// RD_REQ  | ARVALID high, waiting for ARREADY
// RD_RESP | RREADY high, waiting for RVALID
// RSP     | rsp_valid high, holding response until rsp_ready
module axi_lite_master_bridge
  import axil_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            ACLK,
  input  logic            ARESETN,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [DW-1:0]   cmd_wdata,
  input  logic [DW/8-1:0] cmd_wstrb,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_write,
  output logic [DW-1:0]   rsp_rdata,
  output logic [1:0]      rsp_resp,
  output logic [AW-1:0]   M_AXIL_AWADDR,
  output logic            M_AXIL_AWVALID,
  input  logic            M_AXIL_AWREADY,
  output logic [DW-1:0]   M_AXIL_WDATA,
  output logic [DW/8-1:0] M_AXIL_WSTRB,
  output logic            M_AXIL_WVALID,
  input  logic            M_AXIL_WREADY,
  input  logic [1:0]      M_AXIL_BRESP,
  input  logic            M_AXIL_BVALID,
  output logic            M_AXIL_BREADY,
  output logic [AW-1:0]   M_AXIL_ARADDR,
  output logic            M_AXIL_ARVALID,
  input  logic            M_AXIL_ARREADY,
  input  logic [DW-1:0]   M_AXIL_RDATA,
  input  logic [1:0]      M_AXIL_RRESP,
  input  logic            M_AXIL_RVALID,
  output logic            M_AXIL_RREADY
`ifdef AXIL_MST_STATS_EN
  ,
  output logic [31:0]     stat_wr_count,
  output logic [31:0]     stat_rd_count,
  output logic [15:0]     stat_err_count
`endif
);

  mst_state_t      state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic            aw_valid_q, aw_valid_d;
  logic            w_valid_q, w_valid_d;
  logic            b_ready_q, b_ready_d;
  logic            ar_valid_q, ar_valid_d;
  logic            r_ready_q, r_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_write_q, rsp_write_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_valid_d  = aw_valid_q;
    w_valid_d   = w_valid_q;
    b_ready_d   = b_ready_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_write) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = WR_REQ;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        // AW and W complete independently, in either order or together
        if (aw_valid_q && M_AXIL_AWREADY) aw_valid_d = 1'b0;
        if (w_valid_q && M_AXIL_WREADY)   w_valid_d  = 1'b0;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: begin
        if (M_AXIL_BVALID) begin
          b_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXIL_BRESP;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (M_AXIL_ARREADY) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = RD_RESP;
        end
      end
      RD_RESP: begin
        if (M_AXIL_RVALID) begin
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = M_AXIL_RDATA;
          rsp_resp_d  = M_AXIL_RRESP;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign M_AXIL_AWADDR  = addr_q;
  assign M_AXIL_AWVALID = aw_valid_q;
  assign M_AXIL_WDATA   = wdata_q;
  assign M_AXIL_WSTRB   = wstrb_q;
  assign M_AXIL_WVALID  = w_valid_q;
  assign M_AXIL_BREADY  = b_ready_q;
  assign M_AXIL_ARADDR  = addr_q;
  assign M_AXIL_ARVALID = ar_valid_q;
  assign M_AXIL_RREADY  = r_ready_q;

`ifdef AXIL_MST_STATS_EN
  logic       wr_done, rd_done;
  logic [1:0] done_resp;

  assign wr_done   = (state_q == WR_RESP) && M_AXIL_BVALID;
  assign rd_done   = (state_q == RD_RESP) && M_AXIL_RVALID;
  assign done_resp = wr_done ? M_AXIL_BRESP : M_AXIL_RRESP;

  axil_mst_stats u_stats (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .wr_done        (wr_done),
    .rd_done        (rd_done),
    .resp           (done_resp),
    .stat_wr_count  (stat_wr_count),
    .stat_rd_count  (stat_rd_count),
    .stat_err_count (stat_err_count)
  );
`else
  // counters and their ports are not built
`endif

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed self-checking bench: bridge paired with a behavioural AXI-Lite memory slave.
module tb_axi_lite_master_bridge;
  import axil_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXIL_AWADDR, M_AXIL_WDATA, M_AXIL_ARADDR, M_AXIL_RDATA;
  logic [3:0]  M_AXIL_WSTRB;
  logic        M_AXIL_AWVALID, M_AXIL_AWREADY, M_AXIL_WVALID, M_AXIL_WREADY;
  logic        M_AXIL_BVALID, M_AXIL_BREADY, M_AXIL_ARVALID, M_AXIL_ARREADY;
  logic        M_AXIL_RVALID, M_AXIL_RREADY;
  logic [1:0]  M_AXIL_BRESP, M_AXIL_RRESP;
`ifdef AXIL_MST_STATS_EN
  logic [31:0] stat_wr_count, stat_rd_count;
  logic [15:0] stat_err_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 ACLK = ~ACLK;

  axi_lite_master_bridge #(.DW(32), .AW(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXIL_AWADDR(M_AXIL_AWADDR), .M_AXIL_AWVALID(M_AXIL_AWVALID), .M_AXIL_AWREADY(M_AXIL_AWREADY),
    .M_AXIL_WDATA(M_AXIL_WDATA), .M_AXIL_WSTRB(M_AXIL_WSTRB), .M_AXIL_WVALID(M_AXIL_WVALID),
    .M_AXIL_WREADY(M_AXIL_WREADY),
    .M_AXIL_BRESP(M_AXIL_BRESP), .M_AXIL_BVALID(M_AXIL_BVALID), .M_AXIL_BREADY(M_AXIL_BREADY),
    .M_AXIL_ARADDR(M_AXIL_ARADDR), .M_AXIL_ARVALID(M_AXIL_ARVALID), .M_AXIL_ARREADY(M_AXIL_ARREADY),
    .M_AXIL_RDATA(M_AXIL_RDATA), .M_AXIL_RRESP(M_AXIL_RRESP), .M_AXIL_RVALID(M_AXIL_RVALID),
    .M_AXIL_RREADY(M_AXIL_RREADY)
`ifdef AXIL_MST_STATS_EN
    , .stat_wr_count(stat_wr_count), .stat_rd_count(stat_rd_count), .stat_err_count(stat_err_count)
`endif
  );

  // Behavioural memory slave: block = addr[7:6], word = addr[5:0]; ready asserted after a delay.
  logic [31:0] mem [4][64];
  logic        mem_loaded = 1'b0;
  int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
  logic        b_hold = 1'b0, force_err = 1'b0;
  logic        aw_got, w_got;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, ar_cycles = 0;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      if (!mem_loaded) begin
        for (int b = 0; b < 4; b++)
          for (int w = 0; w < 64; w++) mem[b][w] <= {8{b[3:0]}};
        mem_loaded <= 1'b1;
      end
      M_AXIL_AWREADY <= 1'b0; M_AXIL_WREADY <= 1'b0; M_AXIL_BVALID <= 1'b0;
      M_AXIL_ARREADY <= 1'b0; M_AXIL_RVALID <= 1'b0;
      M_AXIL_BRESP <= 2'b00; M_AXIL_RRESP <= 2'b00; M_AXIL_RDATA <= '0;
      aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0; s_araddr <= '0;
    end else begin
      if (M_AXIL_ARVALID) ar_cycles <= ar_cycles + 1;
      if (M_AXIL_AWREADY && M_AXIL_AWVALID) begin
        M_AXIL_AWREADY <= 1'b0; aw_got <= 1'b1; s_awaddr <= M_AXIL_AWADDR;
        aw_hs <= aw_hs + 1; aw_cnt <= 0;
      end else if (M_AXIL_AWVALID && !aw_got && !M_AXIL_AWREADY) begin
        if (aw_cnt >= aw_delay) M_AXIL_AWREADY <= 1'b1;
        else aw_cnt <= aw_cnt + 1;
      end
      if (M_AXIL_WREADY && M_AXIL_WVALID) begin
        M_AXIL_WREADY <= 1'b0; w_got <= 1'b1; s_wdata <= M_AXIL_WDATA; s_wstrb <= M_AXIL_WSTRB;
        w_hs <= w_hs + 1; w_cnt <= 0;
      end else if (M_AXIL_WVALID && !w_got && !M_AXIL_WREADY) begin
        if (w_cnt >= w_delay) M_AXIL_WREADY <= 1'b1;
        else w_cnt <= w_cnt + 1;
      end
      if (M_AXIL_BVALID && M_AXIL_BREADY) begin
        M_AXIL_BVALID <= 1'b0; b_hs <= b_hs + 1;
      end else if (aw_got && w_got && !M_AXIL_BVALID && !b_hold) begin
        for (int b = 0; b < 4; b++)
          if (s_wstrb[b]) mem[s_awaddr[7:6]][s_awaddr[5:0]][8*b +: 8] <= s_wdata[8*b +: 8];
        M_AXIL_BVALID <= 1'b1;
        M_AXIL_BRESP  <= force_err ? RESP_SLVERR : RESP_OKAY;
        aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (M_AXIL_ARREADY && M_AXIL_ARVALID) begin
        M_AXIL_ARREADY <= 1'b0; ar_hs <= ar_hs + 1; s_araddr <= M_AXIL_ARADDR;
        M_AXIL_RVALID  <= 1'b1;
        M_AXIL_RDATA   <= mem[M_AXIL_ARADDR[7:6]][M_AXIL_ARADDR[5:0]];
        M_AXIL_RRESP   <= force_err ? RESP_SLVERR : RESP_OKAY;
      end else if (M_AXIL_ARVALID && !M_AXIL_ARREADY && !M_AXIL_RVALID) begin
        M_AXIL_ARREADY <= 1'b1;
      end
      if (M_AXIL_RVALID && M_AXIL_RREADY) begin
        M_AXIL_RVALID <= 1'b0; r_hs <= r_hs + 1;
      end
    end
  end

  // Protocol watch: a VALID waiting for READY must stay high with stable payload.
  logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [31:0] p_awa, p_wd, p_ara;
  int          proto_err = 0;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      p_awv <= 1'b0; p_awr <= 1'b0; p_wv <= 1'b0; p_wr <= 1'b0; p_arv <= 1'b0; p_arr <= 1'b0;
      p_awa <= '0; p_wd <= '0; p_ara <= '0;
    end else begin
      if ((p_awv && !p_awr && (!M_AXIL_AWVALID || M_AXIL_AWADDR != p_awa)) ||
          (p_wv && !p_wr && (!M_AXIL_WVALID || M_AXIL_WDATA != p_wd)) ||
          (p_arv && !p_arr && (!M_AXIL_ARVALID || M_AXIL_ARADDR != p_ara)))
        proto_err <= proto_err + 1;
      p_awv <= M_AXIL_AWVALID; p_awr <= M_AXIL_AWREADY; p_awa <= M_AXIL_AWADDR;
      p_wv  <= M_AXIL_WVALID;  p_wr  <= M_AXIL_WREADY;  p_wd  <= M_AXIL_WDATA;
      p_arv <= M_AXIL_ARVALID; p_arr <= M_AXIL_ARREADY; p_ara <= M_AXIL_ARADDR;
    end
  end

  // Called just after a falling edge; returns just after a falling edge.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int waits);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    waits = 0;
    while (!cmd_ready && waits < 50) begin @(negedge ACLK); waits++; end
    if (!cmd_ready) begin
      tests++; fails++;
      $display("FAIL cmd_accept timeout: cmd_ready=%0b required 1", cmd_ready);
    end else @(posedge ACLK);
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic w, output logic [31:0] rd, output logic [1:0] rr);
    int n = 0;
    while (!rsp_valid && n < 50) begin @(negedge ACLK); n++; end
    if (!rsp_valid) begin
      tests++; fails++;
      $display("FAIL rsp timeout: rsp_valid=%0b required 1", rsp_valid);
    end
    w = rsp_write; rd = rsp_rdata; rr = rsp_resp;
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 ARESETN = 1'b0;
    #2;
    tests++;
    if ({cmd_ready, rsp_valid, M_AXIL_AWVALID, M_AXIL_WVALID, M_AXIL_BREADY,
         M_AXIL_ARVALID, M_AXIL_RREADY} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got cmd_rdy=%0b rsp_v=%0b awv=%0b wv=%0b br=%0b arv=%0b rr=%0b required all 0",
               cmd_ready, rsp_valid, M_AXIL_AWVALID, M_AXIL_WVALID, M_AXIL_BREADY,
               M_AXIL_ARVALID, M_AXIL_RREADY);
    end
    tests++;
    if ({M_AXIL_AWADDR, M_AXIL_WDATA, M_AXIL_WSTRB, rsp_rdata, rsp_resp, rsp_write} !== '0) begin
      fails++;
      $display("FAIL reset_data: awaddr=%h wdata=%h wstrb=%h rdata=%h resp=%0d required 0",
               M_AXIL_AWADDR, M_AXIL_WDATA, M_AXIL_WSTRB, rsp_rdata, rsp_resp);
    end
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_idle_ready: cmd_ready=%0b required 1", cmd_ready);
    end
  endtask

  task automatic test_read_basic();
    int waits, c0, h0;
    logic w; logic [31:0] rd; logic [1:0] rr;
    c0 = ar_cycles; h0 = ar_hs;
    send_cmd(1'b0, 32'h40, 32'h0, 4'h0, waits);
    get_rsp(w, rd, rr);
    tests++;
    if (rd !== 32'h11111111 || rr !== RESP_OKAY || w !== 1'b0) begin
      fails++; $display("FAIL read_0x40: rdata=%h resp=%0d write=%0b required 11111111/0/0", rd, rr, w);
    end
    tests++;
    if (ar_cycles - c0 != 2 || ar_hs - h0 != 1 || M_AXIL_ARVALID !== 1'b0) begin
      fails++;
      $display("FAIL arvalid_span: cycles=%0d hs=%0d arvalid=%0b required 2/1/0",
               ar_cycles - c0, ar_hs - h0, M_AXIL_ARVALID);
    end
    tests++;
    if (s_araddr !== 32'h40) begin
      fails++; $display("FAIL araddr: got %h required 00000040", s_araddr);
    end
  endtask

  task automatic test_write_read();
    int waits;
    logic w; logic [31:0] rd; logic [1:0] rr;
    send_cmd(1'b1, 32'h85, 32'hDEADBEEF, 4'b0011, waits);
    get_rsp(w, rd, rr);
    tests++;
    if (rr !== RESP_OKAY || w !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL write_0x85_rsp: resp=%0d write=%0b rdata=%h required 0/1/0", rr, w, rd);
    end
    send_cmd(1'b0, 32'h85, 32'h0, 4'h0, waits);
    get_rsp(w, rd, rr);
    tests++;
    if (rd !== 32'h2222BEEF || rr !== RESP_OKAY || w !== 1'b0) begin
      fails++; $display("FAIL readback_0x85: rdata=%h resp=%0d required 2222BEEF/0", rd, rr);
    end
  endtask

  task automatic test_aw_w_skew();
    int          awd [3] = '{3, 0, 2};
    int          wd  [3] = '{0, 3, 2};
    logic [31:0] adr [3] = '{32'h01, 32'h42, 32'hC3};
    logic [31:0] dat [3] = '{32'hA5A5A5A5, 32'h12345678, 32'h0000FF00};
    logic [3:0]  stb [3] = '{4'hF, 4'b1100, 4'b0010};
    logic [31:0] exp [3] = '{32'hA5A5A5A5, 32'h12341111, 32'h3333FF33};
    for (int i = 0; i < 3; i++) begin
      int waits, a0, w0, b0;
      logic w; logic [31:0] rd; logic [1:0] rr;
      aw_delay = awd[i]; w_delay = wd[i];
      a0 = aw_hs; w0 = w_hs; b0 = b_hs;
      send_cmd(1'b1, adr[i], dat[i], stb[i], waits);
      get_rsp(w, rd, rr);
      tests++;
      if (rr !== RESP_OKAY || w !== 1'b1) begin
        fails++; $display("FAIL skew%0d_rsp: resp=%0d write=%0b required 0/1", i, rr, w);
      end
      tests++;
      if (aw_hs - a0 != 1 || w_hs - w0 != 1 || b_hs - b0 != 1) begin
        fails++;
        $display("FAIL skew%0d_hs: aw=%0d w=%0d b=%0d required 1/1/1", i, aw_hs - a0, w_hs - w0, b_hs - b0);
      end
      tests++;
      if (mem[adr[i][7:6]][adr[i][5:0]] !== exp[i] || s_awaddr !== adr[i]) begin
        fails++;
        $display("FAIL skew%0d_mem: word=%h awaddr=%h required %h/%h", i,
                 mem[adr[i][7:6]][adr[i][5:0]], s_awaddr, exp[i], adr[i]);
      end
    end
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_rsp_hold();
    int waits, n;
    logic w; logic [31:0] rd; logic [1:0] rr;
    send_cmd(1'b0, 32'hC0, 32'h0, 4'h0, waits);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge ACLK); n++; end
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h33333333 || rsp_resp !== RESP_OKAY ||
          rsp_write !== 1'b0 || cmd_ready !== 1'b0) begin
        fails++;
        $display("FAIL hold_c%0d: v=%0b rdata=%h resp=%0d wr=%0b cmd_rdy=%0b required 1/33333333/0/0/0",
                 c, rsp_valid, rsp_rdata, rsp_resp, rsp_write, cmd_ready);
      end
      @(negedge ACLK);
    end
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    tests++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      fails++; $display("FAIL post_rsp_idle: cmd_ready=%0b rsp_valid=%0b required 1/0", cmd_ready, rsp_valid);
    end
    send_cmd(1'b0, 32'h00, 32'h0, 4'h0, waits);
    tests++;
    if (waits != 0) begin
      fails++; $display("FAIL back_to_back: waits=%0d required 0", waits);
    end
    get_rsp(w, rd, rr);
    tests++;
    if (rd !== 32'h0 || rr !== RESP_OKAY) begin
      fails++; $display("FAIL read_0x00: rdata=%h resp=%0d required 0/0", rd, rr);
    end
  endtask

  task automatic test_error();
    int waits;
    logic w; logic [31:0] rd; logic [1:0] rr;
    force_err = 1'b1;
    send_cmd(1'b1, 32'h10, 32'h00000055, 4'hF, waits);
    get_rsp(w, rd, rr);
    tests++;
    if (rr !== RESP_SLVERR || w !== 1'b1) begin
      fails++; $display("FAIL err_write: resp=%0d write=%0b required 2/1", rr, w);
    end
    send_cmd(1'b0, 32'h10, 32'h0, 4'h0, waits);
    get_rsp(w, rd, rr);
    tests++;
    if (rr !== RESP_SLVERR || rd !== 32'h00000055) begin
      fails++; $display("FAIL err_read: resp=%0d rdata=%h required 2/00000055", rr, rd);
    end
    force_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    int waits, n;
    logic w; logic [31:0] rd; logic [1:0] rr;
    b_hold = 1'b1;
    send_cmd(1'b1, 32'hC0, 32'hFFFFFFFF, 4'hF, waits);
    n = 0;
    while (!M_AXIL_BREADY && n < 50) begin @(negedge ACLK); n++; end
    tests++;
    if (M_AXIL_BREADY !== 1'b1) begin
      fails++; $display("FAIL reach_wr_resp: bready=%0b required 1", M_AXIL_BREADY);
    end
    #2 ARESETN = 1'b0;
    #1;
    tests++;
    if ({M_AXIL_AWVALID, M_AXIL_WVALID, M_AXIL_BREADY, M_AXIL_ARVALID, M_AXIL_RREADY,
         rsp_valid, cmd_ready} !== 7'b0 || M_AXIL_AWADDR !== 32'h0) begin
      fails++;
      $display("FAIL async_reset: awv=%0b wv=%0b br=%0b arv=%0b rr=%0b rsp_v=%0b cmd_rdy=%0b awaddr=%h required 0",
               M_AXIL_AWVALID, M_AXIL_WVALID, M_AXIL_BREADY, M_AXIL_ARVALID, M_AXIL_RREADY,
               rsp_valid, cmd_ready, M_AXIL_AWADDR);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
    b_hold = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge ACLK);
      tests++;
      if (rsp_valid !== 1'b0) begin
        fails++; $display("FAIL lost_cmd_c%0d: rsp_valid=%0b required 0", c, rsp_valid);
      end
    end
    send_cmd(1'b0, 32'hC0, 32'h0, 4'h0, waits);
    get_rsp(w, rd, rr);
    tests++;
    if (rd !== 32'h33333333 || rr !== RESP_OKAY) begin
      fails++; $display("FAIL read_0xC0_after_reset: rdata=%h resp=%0d required 33333333/0", rd, rr);
    end
  endtask

`ifdef AXIL_MST_STATS_EN
  task automatic test_stats();
    int waits;
    logic w; logic [31:0] rd; logic [1:0] rr;
    #2 ARESETN = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    tests++;
    if (stat_wr_count !== 32'd0 || stat_rd_count !== 32'd0 || stat_err_count !== 16'd0) begin
      fails++; $display("FAIL stats_reset: wr=%0d rd=%0d err=%0d required 0", stat_wr_count,
                        stat_rd_count, stat_err_count);
    end
    @(negedge ACLK);
    for (int i = 0; i < 3; i++) begin
      send_cmd(1'b1, 32'h20 + i, 32'h0 + i, 4'hF, waits);
      get_rsp(w, rd, rr);
    end
    send_cmd(1'b0, 32'h20, 32'h0, 4'h0, waits);
    get_rsp(w, rd, rr);
    force_err = 1'b1;
    send_cmd(1'b0, 32'h21, 32'h0, 4'h0, waits);
    get_rsp(w, rd, rr);
    force_err = 1'b0;
    tests++;
    if (stat_wr_count !== 32'd3 || stat_rd_count !== 32'd2 || stat_err_count !== 16'd1) begin
      fails++; $display("FAIL stats_counts: wr=%0d rd=%0d err=%0d required 3/2/1", stat_wr_count,
                        stat_rd_count, stat_err_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write_read();
    test_aw_w_skew();
    test_rsp_hold();
    test_error();
    test_reset_mid();
`ifdef AXIL_MST_STATS_EN
    test_stats();
`endif
    tests++;
    if (proto_err != 0) begin
      fails++; $display("FAIL valid_stability: violations=%0d required 0", proto_err);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
